// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, ROM enable and the IF/ID pipeline register.
// Optional fetched-instruction counter is built when IF_FETCH_CNT_EN is defined.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic        flush,
   input  logic [31:0] new_pc,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_addr_i,
   input  logic [31:0] rom_inst_i,
   output logic [31:0] pc_o,
   output logic        ce_o,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_inst_o
`ifdef IF_FETCH_CNT_EN
   ,
   output logic [31:0] fetch_cnt_o
`endif
);

   localparam int DATA_W = 32;

   logic stall_pc, stall_if, stall_id;
   logic unused_stall_bits;

   assign stall_pc          = stall[0];
   assign stall_if          = stall[1];
   assign stall_id          = stall[2];
   assign unused_stall_bits = ^stall[5:3];

   function automatic logic [DATA_W-1:0] seq_pc(input logic [DATA_W-1:0] pc);
      return pc + 32'd4;
   endfunction

   // PC stage: the ROM stays disabled (and the PC parked) for one cycle after reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ce_o <= 1'b0;
         pc_o <= RESET_PC;
      end else begin
         ce_o <= 1'b1;
         if (!ce_o)
            pc_o <= RESET_PC;
         else if (flush)
            pc_o <= new_pc;
         else if (stall_pc)
            pc_o <= pc_o;
         else if (branch_flag_i)
            pc_o <= branch_target_addr_i;
         else
            pc_o <= seq_pc(pc_o);
      end
   end

   // IF/ID boundary: a disabled ROM reads as zero, so the captured word is gated by ce_o
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         id_pc_o   <= '0;
         id_inst_o <= '0;
      end else if (flush) begin
         id_pc_o   <= '0;
         id_inst_o <= '0;
      end else if (stall_if && !stall_id) begin
         id_pc_o   <= '0;
         id_inst_o <= '0;
      end else if (!stall_if) begin
         id_pc_o   <= pc_o;
         id_inst_o <= ce_o ? rom_inst_i : '0;
      end
   end

`ifdef IF_FETCH_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         fetch_cnt_o <= '0;
      else if (ce_o && !stall_if && !flush)
         fetch_cnt_o <= fetch_cnt_o + 32'd1;
   end
`endif

endmodule
